// File: rtl/vvp_seq_if.sv
// rtl/vvp_seq_if.sv - job, result and vvp-side signal bundle for vvp_seq
interface vvp_seq_if #(
   parameter int N = 64,
   parameter int B = 8
);
   localparam int A  = $clog2(N);
   localparam int SW = A + 2;
   localparam int RW = A + 2 + B;
   localparam int CW = $clog2(B + 1);

   // job request
   logic                 start_valid;
   logic                 start_ready;
   logic [1:0]           cfg_mode;
   logic [CW-1:0]        cfg_bits;
   logic                 cfg_signed;
   logic [N-1:0]         cfg_W;
   logic [N*B-1:0]       cfg_D;

   // datapath side
   logic [1:0]           vvp_mode;
   logic [N-1:0]         vvp_W;
   logic [N-1:0]         vvp_D;
   logic signed [SW-1:0] vvp_S;

   // result
   logic                 res_valid;
   logic                 res_ready;
   logic signed [RW-1:0] res_data;

   // master: job issuer plus the attached vvp instance
   modport master (
      output start_valid, cfg_mode, cfg_bits, cfg_signed, cfg_W, cfg_D,
      output res_ready, vvp_S,
      input  start_ready, res_valid, res_data, vvp_mode, vvp_W, vvp_D
   );

   // slave: the sequencer itself
   modport slave (
      input  start_valid, cfg_mode, cfg_bits, cfg_signed, cfg_W, cfg_D,
      input  res_ready, vvp_S,
      output start_ready, res_valid, res_data, vvp_mode, vvp_W, vvp_D
   );
endinterface

// File: rtl/vvp_seq.sv
// rtl/vvp_seq.sv - bit-serial sequencer driving one vvp dot-product datapath
module vvp_seq #(
   parameter int N    = 64,
   parameter int B    = 8,
   parameter int PLAT = 0
) (
   input logic      clk,
   input logic      rst_n,
   vvp_seq_if.slave bus
);
   localparam int A  = $clog2(N);
   localparam int SW = A + 2;
   localparam int RW = A + 2 + B;
   localparam int CW = $clog2(B + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t               state;
   logic [1:0]           mode_q;
   logic [N-1:0]         w_q;
   logic [N*B-1:0]       d_q;
   logic                 sgn_q;
   logic [CW-1:0]        k_q;
   logic [CW-1:0]        icnt;
   logic [CW-1:0]        rcnt;
   logic [CW-1:0]        k_in;
   logic [N-1:0]         plane_q;
   // tag stage 0 is aligned with plane_q; stage PLAT is aligned with vvp_S
   logic [PLAT:0]        tag_v;
   logic [PLAT:0]        tag_m;
   logic signed [RW-1:0] acc;
   logic signed [RW-1:0] s_ext;
   logic signed [RW-1:0] x;
   logic                 res_v;

   // clamp requested precision into 1..B
   always_comb begin
      k_in = bus.cfg_bits;
      if (bus.cfg_bits == '0) begin
         k_in = CW'(1);
      end else if (bus.cfg_bits > CW'(B)) begin
         k_in = CW'(B);
      end
   end

   // sign-extend the returning partial sum; the MSB plane of a signed job weighs negative
   always_comb begin
      s_ext = {{(RW-SW){bus.vvp_S[SW-1]}}, bus.vvp_S};
      x     = (tag_m[PLAT] && sgn_q) ? -s_ext : s_ext;
   end

   // job FSM, plane issue, tag pipe and shift-and-add accumulation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         mode_q  <= '0;
         w_q     <= '0;
         d_q     <= '0;
         sgn_q   <= 1'b0;
         k_q     <= '0;
         icnt    <= '0;
         rcnt    <= '0;
         plane_q <= '0;
         tag_v   <= '0;
         tag_m   <= '0;
         acc     <= '0;
         res_v   <= 1'b0;
      end else begin
         plane_q  <= '0;
         tag_v[0] <= 1'b0;
         tag_m[0] <= 1'b0;
         for (int i = 1; i <= PLAT; i++) begin
            tag_v[i] <= tag_v[i-1];
            tag_m[i] <= tag_m[i-1];
         end

         if (tag_v[PLAT]) begin
            acc  <= (acc <<< 1) + x;
            rcnt <= rcnt + CW'(1);
         end

         case (state)
            IDLE: begin
               if (bus.start_valid) begin
                  mode_q <= bus.cfg_mode;
                  w_q    <= bus.cfg_W;
                  d_q    <= bus.cfg_D;
                  sgn_q  <= bus.cfg_signed;
                  k_q    <= k_in;
                  icnt   <= k_in - CW'(1);
                  rcnt   <= '0;
                  acc    <= '0;
                  state  <= ISSUE;
               end
            end
            ISSUE: begin
               plane_q  <= d_q[icnt*N +: N];
               tag_v[0] <= 1'b1;
               tag_m[0] <= (icnt == k_q - CW'(1));
               if (icnt == '0) begin
                  state <= DRAIN;
               end else begin
                  icnt <= icnt - CW'(1);
               end
            end
            DRAIN: begin
               if (tag_v[PLAT] && (rcnt == k_q - CW'(1))) begin
                  res_v <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               if (bus.res_ready) begin
                  res_v <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.start_ready = (state == IDLE);
   assign bus.vvp_mode    = mode_q;
   assign bus.vvp_W       = w_q;
   assign bus.vvp_D       = plane_q;
   assign bus.res_valid   = res_v;
   assign bus.res_data    = acc;
endmodule

// File: tb/tb_vvp_seq.sv
// tb/tb_vvp_seq.sv - self-checking bench for vvp_seq with PLAT=0 and PLAT=3 instances
module tb_vvp_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   vvp_seq_if #(.N(64), .B(8)) if0 ();
   vvp_seq_if #(.N(64), .B(8)) if3 ();

   vvp_seq #(.N(64), .B(8), .PLAT(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   vvp_seq #(.N(64), .B(8), .PLAT(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

   // bench-side drive and observe arrays, index 0 -> PLAT=0, index 1 -> PLAT=3
   logic               start_valid [2];
   logic [1:0]         cfg_mode    [2];
   logic [3:0]         cfg_bits    [2];
   logic               cfg_signed  [2];
   logic [63:0]        cfg_w       [2];
   logic [511:0]       cfg_d       [2];
   logic               res_ready   [2];
   logic               start_ready [2];
   logic               res_valid   [2];
   logic signed [15:0] res_data    [2];
   logic [63:0]        vvp_d       [2];
   logic [63:0]        vvp_w       [2];
   logic [1:0]         vvp_m       [2];

   assign if0.start_valid = start_valid[0];
   assign if0.cfg_mode    = cfg_mode[0];
   assign if0.cfg_bits    = cfg_bits[0];
   assign if0.cfg_signed  = cfg_signed[0];
   assign if0.cfg_W       = cfg_w[0];
   assign if0.cfg_D       = cfg_d[0];
   assign if0.res_ready   = res_ready[0];
   assign if3.start_valid = start_valid[1];
   assign if3.cfg_mode    = cfg_mode[1];
   assign if3.cfg_bits    = cfg_bits[1];
   assign if3.cfg_signed  = cfg_signed[1];
   assign if3.cfg_W       = cfg_w[1];
   assign if3.cfg_D       = cfg_d[1];
   assign if3.res_ready   = res_ready[1];

   assign start_ready[0] = if0.start_ready;
   assign res_valid[0]   = if0.res_valid;
   assign res_data[0]    = if0.res_data;
   assign vvp_d[0]       = if0.vvp_D;
   assign vvp_w[0]       = if0.vvp_W;
   assign vvp_m[0]       = if0.vvp_mode;
   assign start_ready[1] = if3.start_ready;
   assign res_valid[1]   = if3.res_valid;
   assign res_data[1]    = if3.res_data;
   assign vvp_d[1]       = if3.vvp_D;
   assign vvp_w[1]       = if3.vvp_W;
   assign vvp_m[1]       = if3.vvp_mode;

   // stand-in vvp: 00 zero, 01 popcount(W&D), 10 sum of D weighted -1 where W else +1, 11 popcount(~W&D)
   function automatic int vvp_sum(input logic [1:0] m, input logic [63:0] w, input logic [63:0] d);
      int s;
      s = 0;
      for (int i = 0; i < 64; i++) begin
         case (m)
            2'b01:   if (d[i] && w[i]) s++;
            2'b10:   if (d[i]) s += (w[i] ? -1 : 1);
            2'b11:   if (d[i] && !w[i]) s++;
            default: ;
         endcase
      end
      return s;
   endfunction

   always_comb if0.vvp_S = 8'(vvp_sum(if0.vvp_mode, if0.vvp_W, if0.vvp_D));

   logic signed [7:0] p3 [3];
   always_ff @(posedge clk) begin
      p3[0] <= 8'(vvp_sum(if3.vvp_mode, if3.vvp_W, if3.vvp_D));
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign if3.vvp_S = p3[2];

   // reference: whole-integer dot product of the K-bit activations with per-mode weights
   function automatic int ref_dot(input logic [1:0] m, input logic [3:0] bits, input logic sg,
                                  input logic [63:0] w, input logic [511:0] d);
      int k;
      int tot;
      int a;
      k = (bits == 0) ? 1 : ((bits > 8) ? 8 : int'(bits));
      tot = 0;
      for (int i = 0; i < 64; i++) begin
         a = 0;
         for (int b = 0; b < k; b++) if (d[b*64+i]) a += (1 << b);
         if (sg && d[(k-1)*64+i]) a -= (1 << k);
         case (m)
            2'b01:   if (w[i]) tot += a;
            2'b10:   tot += (w[i] ? -a : a);
            2'b11:   if (!w[i]) tot += a;
            default: ;
         endcase
      end
      return tot;
   endfunction

   function automatic logic [511:0] mk_d(input int val);
      logic [511:0] d;
      logic [7:0]   v;
      v = 8'(val);
      d = '0;
      for (int i = 0; i < 64; i++)
         for (int b = 0; b < 8; b++) d[b*64+i] = v[b];
      return d;
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // one job: accept, count issue cycles, measure latency, optionally stall, then handshake
   task automatic run_job(input int s, input logic [1:0] m, input logic [3:0] bits, input logic sg,
                          input logic [63:0] w, input logic [511:0] d, input int hold,
                          output int res, output int lat, output int niss);
      int c;
      @(negedge clk);
      chk("start_ready_idle", start_ready[s], 1);
      cfg_mode[s] = m; cfg_bits[s] = bits; cfg_signed[s] = sg;
      cfg_w[s] = w; cfg_d[s] = d; start_valid[s] = 1'b1;
      @(negedge clk);
      start_valid[s] = 1'b0;
      c = 0; lat = -1; niss = 0;
      while (c < 100 && lat < 0) begin
         if (vvp_d[s] != '0) niss++;
         if (res_valid[s]) lat = c;
         else begin
            @(negedge clk);
            c++;
         end
      end
      res = int'(res_data[s]);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_res_data", res_data[s], res);
         chk("hold_res_valid", res_valid[s], 1);
         chk("hold_start_ready", start_ready[s], 0);
      end
      res_ready[s] = 1'b1;
      @(negedge clk);
      res_ready[s] = 1'b0;
      chk("start_ready_after", start_ready[s], 1);
      chk("res_valid_after", res_valid[s], 0);
   endtask

   task automatic rand_job(output logic [1:0] m, output logic [3:0] bits, output logic sg,
                           output logic [63:0] w, output logic [511:0] d);
      m = 2'($urandom_range(0, 3));
      bits = 4'($urandom_range(0, 15));
      sg = 1'($urandom_range(0, 1));
      w = {$urandom, $urandom};
      for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
   endtask

   // back-to-back random jobs with random res_ready, scoreboarded in accept order
   task automatic rand_run(input int s, input int nj);
      int q[$];
      int sent, got, cyc, e;
      logic [1:0] m; logic [3:0] bits; logic sg; logic [63:0] w; logic [511:0] d;
      sent = 0; got = 0; cyc = 0;
      rand_job(m, bits, sg, w, d);
      while (got < nj && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         cfg_mode[s] = m; cfg_bits[s] = bits; cfg_signed[s] = sg; cfg_w[s] = w; cfg_d[s] = d;
         start_valid[s] = (sent < nj);
         res_ready[s] = 1'($urandom_range(0, 1));
         if (start_valid[s] && start_ready[s]) begin
            q.push_back(ref_dot(m, bits, sg, w, d));
            sent++;
            rand_job(m, bits, sg, w, d);
         end
         if (res_valid[s] && res_ready[s]) begin
            if (q.size() == 0) chk("rand_duplicate", 1, 0);
            else begin
               e = q.pop_front();
               chk("rand_result", res_data[s], e);
            end
            got++;
         end
      end
      @(negedge clk);
      start_valid[s] = 1'b0;
      res_ready[s] = 1'b0;
      chk("rand_count", got, nj);
      chk("rand_pending", q.size(), 0);
   endtask

   typedef struct {
      logic [1:0]   mode;
      logic [3:0]   bits;
      logic         sgn;
      logic [63:0]  w;
      logic [511:0] d;
      int           exp_res;
      int           exp_lat;
      int           exp_iss;
   } vec_t;

   vec_t tv[8];

   initial begin
      int res, lat, niss;
      logic [63:0] ones;
      ones = '1;
      for (int s = 0; s < 2; s++) begin
         start_valid[s] = 0; cfg_mode[s] = 0; cfg_bits[s] = 0; cfg_signed[s] = 0;
         cfg_w[s] = 0; cfg_d[s] = 0; res_ready[s] = 0;
      end

      tv[0] = '{2'b01, 4'd2,  1'b0, ones,   mk_d(3),   192,   3, 2};
      tv[1] = '{2'b01, 4'd2,  1'b1, ones,   mk_d(3),   -64,   3, 2};
      tv[2] = '{2'b10, 4'd4,  1'b0, ones,   mk_d(5),   -320,  5, -1};
      tv[3] = '{2'b10, 4'd4,  1'b0, 64'h0,  mk_d(5),   320,   5, -1};
      tv[4] = '{2'b00, 4'd8,  1'b1, 64'h0123456789abcdef, mk_d(90), 0, 9, -1};
      tv[5] = '{2'b01, 4'd0,  1'b0, ones,   mk_d(255), 64,    2, 1};
      tv[6] = '{2'b01, 4'd15, 1'b0, ones,   mk_d(255), 16320, 9, 8};
      tv[7] = '{2'b01, 4'd8,  1'b1, ones,   mk_d(255), -64,   9, 8};

      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         chk("rst_start_ready", start_ready[s], 1);
         chk("rst_res_valid", res_valid[s], 0);
         chk("rst_res_data", res_data[s], 0);
         chk("rst_vvp_d", vvp_d[s], 0);
      end
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_job(0, tv[i].mode, tv[i].bits, tv[i].sgn, tv[i].w, tv[i].d, 0, res, lat, niss);
         chk($sformatf("vec%0d_res", i), res, tv[i].exp_res);
         chk($sformatf("vec%0d_lat", i), lat, tv[i].exp_lat);
         if (tv[i].exp_iss >= 0) chk($sformatf("vec%0d_issue", i), niss, tv[i].exp_iss);
      end

      // deeper pipeline, stalled result consumer
      run_job(1, 2'b01, 4'd2, 1'b0, ones, mk_d(3), 10, res, lat, niss);
      chk("plat3_res", res, 192);
      chk("plat3_lat", lat, 6);
      chk("plat3_issue", niss, 2);

      // reset in the middle of issue
      @(negedge clk);
      cfg_mode[0] = 2'b01; cfg_bits[0] = 4'd4; cfg_signed[0] = 0;
      cfg_w[0] = ones; cfg_d[0] = mk_d(255); start_valid[0] = 1'b1;
      @(negedge clk);
      start_valid[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("midjob_issuing", vvp_d[0], ones);
      rst_n = 1'b0;
      #1;
      chk("midrst_start_ready", start_ready[0], 1);
      chk("midrst_res_valid", res_valid[0], 0);
      chk("midrst_res_data", res_data[0], 0);
      chk("midrst_vvp_d", vvp_d[0], 0);
      chk("midrst_vvp_w", vvp_w[0], 0);
      chk("midrst_vvp_mode", vvp_m[0], 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_job(0, 2'b01, 4'd2, 1'b0, ones, mk_d(3), 0, res, lat, niss);
      chk("postrst_res", res, 192);
      chk("postrst_lat", lat, 3);

      rand_run(0, 40);
      rand_run(1, 40);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
